// File: rtl/pc_ctrl_if.sv
// Fetch-side bus of the program-counter unit: redirect requests in, fetch PC and status out.
// pc_write is the only flow control: 1 lets the PC advance this edge, 0 stalls fetch.
interface pc_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             pc_write;
  logic [1:0]       pc_src;
  logic [WIDTH-1:0] beq_target;
  logic [WIDTH-1:0] jr_target;
  logic [WIDTH-1:0] pc_4_id;
  logic [WIDTH-5:0] jump_off;
  logic             exc;
  logic [WIDTH-1:0] exc_pc;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next_seq;
  logic [WIDTH-1:0] epc;
  logic             redirect_pending;
  logic             misaligned;

  modport master (
    output pc_write, pc_src, beq_target, jr_target, pc_4_id, jump_off, exc, exc_pc, eret,
    input  pc, pc_next_seq, epc, redirect_pending, misaligned
  );

  modport slave (
    input  pc_write, pc_src, beq_target, jr_target, pc_4_id, jump_off, exc, exc_pc, eret,
    output pc, pc_next_seq, epc, redirect_pending, misaligned
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program counter with reset/exception vectors, EPC register and a one-deep buffer
// that holds a redirect resolved while fetch is stalled.
module pc_ctrl #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(128)
) (
  input logic        clk,
  input logic        rst,
  pc_ctrl_if.slave   bus
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] pend_target_q;
  logic             pend_q;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] seq;

  always_comb begin
    target = '0;
    case (bus.pc_src)
      2'b01:   target = {bus.pc_4_id[WIDTH-1:WIDTH-4], bus.jump_off};
      2'b10:   target = bus.beq_target;
      2'b11:   target = bus.jr_target;
      default: target = '0;
    endcase
  end

  assign seq = pc_q + WIDTH'(STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      epc_q         <= '0;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
    end else if (bus.exc) begin
      pc_q   <= EXC_VECTOR;
      epc_q  <= bus.exc_pc;
      pend_q <= 1'b0;
    end else if (bus.eret) begin
      pc_q   <= epc_q;
      pend_q <= 1'b0;
    end else if (bus.pc_write) begin
      // A fresh redirect supersedes whatever was buffered during the stall.
      if (bus.pc_src != 2'b00) begin
        pc_q <= target;
      end else if (pend_q) begin
        pc_q <= pend_target_q;
      end else begin
        pc_q <= seq;
      end
      pend_q <= 1'b0;
    end else if (bus.pc_src != 2'b00) begin
      pend_target_q <= target;
      pend_q        <= 1'b1;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_next_seq      = seq;
  assign bus.epc              = epc_q;
  assign bus.redirect_pending = pend_q;
  assign bus.misaligned       = |(pc_q & WIDTH'(STEP - 1));

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: a 32-bit default instance and a 16-bit STEP=2 instance
// driven with hand-computed vectors.
module tb_pc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_ctrl_if #(.WIDTH(32)) bus32 ();
  pc_ctrl_if #(.WIDTH(16)) bus16 ();

  pc_ctrl #(.WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  pc_ctrl #(.WIDTH(16), .STEP(2), .RESET_VECTOR(16'h0100), .EXC_VECTOR(16'h0080)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus32.pc_write = 1'b0; bus32.pc_src = 2'b00; bus32.beq_target = '0; bus32.jr_target = '0;
    bus32.pc_4_id = '0; bus32.jump_off = '0; bus32.exc = 1'b0; bus32.exc_pc = '0; bus32.eret = 1'b0;
    bus16.pc_write = 1'b0; bus16.pc_src = 2'b00; bus16.beq_target = '0; bus16.jr_target = '0;
    bus16.pc_4_id = '0; bus16.jump_off = '0; bus16.exc = 1'b0; bus16.exc_pc = '0; bus16.eret = 1'b0;

    // Reset and sequential stepping
    step();
    check("rst_pc", bus32.pc, 32'h0);
    check("rst_epc", bus32.epc, 32'h0);
    check("rst_pend", {31'b0, bus32.redirect_pending}, 32'h0);
    rst = 1'b0;
    bus32.pc_write = 1'b1;
    step(); check("seq_4", bus32.pc, 32'h4);
    step(); check("seq_8", bus32.pc, 32'h8);
    step(); check("seq_12", bus32.pc, 32'hC);
    check("next_seq_16", bus32.pc_next_seq, 32'h10);

    // Wrap-around at the top of the address space
    bus32.pc_src = 2'b11; bus32.jr_target = 32'hFFFF_FFFC;
    step(); check("jr_top", bus32.pc, 32'hFFFF_FFFC);
    check("next_seq_wrap", bus32.pc_next_seq, 32'h0);
    bus32.pc_src = 2'b00;
    step(); check("wrap_0", bus32.pc, 32'h0);
    step(); step(); check("at_8", bus32.pc, 32'h8);

    // Redirect decode
    bus32.pc_src = 2'b10; bus32.beq_target = 32'h40;
    step(); check("beq", bus32.pc, 32'h40);
    bus32.pc_src = 2'b01; bus32.pc_4_id = 32'hA000_0010; bus32.jump_off = 28'h0000100;
    step(); check("jump", bus32.pc, 32'hA000_0100);
    bus32.pc_src = 2'b11; bus32.jr_target = 32'h1234;
    step(); check("jr", bus32.pc, 32'h1234);
    check("aligned", {31'b0, bus32.misaligned}, 32'h0);

    // Redirect during stall is buffered and applied on release
    bus32.pc_write = 1'b0; bus32.pc_src = 2'b10; bus32.beq_target = 32'h200;
    step(); check("stall_hold", bus32.pc, 32'h1234);
    check("stall_pend", {31'b0, bus32.redirect_pending}, 32'h1);
    bus32.pc_src = 2'b00;
    step(); step(); check("stall_hold2", bus32.pc, 32'h1234);
    check("stall_pend2", {31'b0, bus32.redirect_pending}, 32'h1);
    bus32.pc_write = 1'b1;
    step(); check("release", bus32.pc, 32'h200);
    check("release_pend", {31'b0, bus32.redirect_pending}, 32'h0);

    // Newer redirect at release supersedes the buffered one
    bus32.pc_write = 1'b0; bus32.pc_src = 2'b10; bus32.beq_target = 32'h280;
    step(); check("stall2_pend", {31'b0, bus32.redirect_pending}, 32'h1);
    bus32.pc_src = 2'b00;
    step();
    bus32.pc_write = 1'b1; bus32.pc_src = 2'b11; bus32.jr_target = 32'h300;
    step(); check("new_wins", bus32.pc, 32'h300);
    bus32.pc_src = 2'b00;
    step(); check("after_new", bus32.pc, 32'h304);

    // Exception and return
    bus32.pc_src = 2'b11; bus32.jr_target = 32'h50;
    step(); check("at_50", bus32.pc, 32'h50);
    bus32.pc_write = 1'b0; bus32.pc_src = 2'b10; bus32.beq_target = 32'h900;
    step(); check("exc_pre_pend", {31'b0, bus32.redirect_pending}, 32'h1);
    bus32.pc_src = 2'b00; bus32.exc = 1'b1; bus32.exc_pc = 32'h4C;
    step(); check("exc_pc", bus32.pc, 32'h80);
    check("exc_epc", bus32.epc, 32'h4C);
    check("exc_pend", {31'b0, bus32.redirect_pending}, 32'h0);
    bus32.exc = 1'b0; bus32.pc_write = 1'b1;
    step(); check("handler", bus32.pc, 32'h84);
    bus32.eret = 1'b1;
    step(); check("eret", bus32.pc, 32'h4C);
    check("eret_epc", bus32.epc, 32'h4C);
    bus32.eret = 1'b0;
    step(); check("post_eret", bus32.pc, 32'h50);

    // exc and eret on the same edge: exc wins
    bus32.exc = 1'b1; bus32.exc_pc = 32'h10; bus32.eret = 1'b1;
    bus32.pc_src = 2'b10; bus32.beq_target = 32'h40;
    step(); check("exc_eret_pc", bus32.pc, 32'h80);
    check("exc_eret_epc", bus32.epc, 32'h10);
    bus32.exc = 1'b0; bus32.eret = 1'b0;

    // Reset in the middle of a stall with a buffered redirect
    bus32.pc_write = 1'b0; bus32.pc_src = 2'b10; bus32.beq_target = 32'h500;
    step(); check("mid_pend", {31'b0, bus32.redirect_pending}, 32'h1);
    bus32.pc_src = 2'b00; rst = 1'b1;
    step(); check("mid_rst_pc", bus32.pc, 32'h0);
    check("mid_rst_pend", {31'b0, bus32.redirect_pending}, 32'h0);
    check("mid_rst_epc", bus32.epc, 32'h0);

    // 16-bit instance, STEP=2, reset vector 0x0100
    check("w16_rst", {16'b0, bus16.pc}, 32'h0100);
    rst = 1'b0;
    bus16.pc_write = 1'b1;
    step(); check("w16_102", {16'b0, bus16.pc}, 32'h0102);
    step(); check("w16_104", {16'b0, bus16.pc}, 32'h0104);
    check("w16_aligned", {31'b0, bus16.misaligned}, 32'h0);
    bus16.pc_src = 2'b11; bus16.jr_target = 16'h0101;
    step(); check("w16_jr", {16'b0, bus16.pc}, 32'h0101);
    check("w16_misaligned", {31'b0, bus16.misaligned}, 32'h1);
    check("w16_next_seq", {16'b0, bus16.pc_next_seq}, 32'h0103);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter unit for the pipelined core. It replaces the fixed 32-bit PC register and adds a synchronous reset vector, an exception/ERET path with an EPC register, and a pending-redirect buffer. The buffer means a branch or jump resolved while fetch is stalled is no longer lost. It sits at the head of IF and feeds the instruction-memory address and the IF/ID PC+step.

Parameters:
WIDTH, 32, PC/address width in bits (>= 8)
STEP, 4, sequential increment in bytes (power of two, < 2^(WIDTH-4))
RESET_VECTOR, 0, PC value loaded on reset
EXC_VECTOR, 'h80, PC value loaded on exception

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc_write  in  1  1 = PC may advance; 0 = fetch stall
pc_src  in  2  00 sequential, 01 jump, 10 branch (beq), 11 register jump (jr)
beq_target  in  WIDTH  branch target from EX
jr_target  in  WIDTH  register-jump target
pc_4_id  in  WIDTH  PC+STEP of the instruction in ID; top 4 bits used for jump
jump_off  in  WIDTH-4  pre-shifted jump offset (low WIDTH-4 bits of target)
exc  in  1  exception: redirect to EXC_VECTOR
exc_pc  in  WIDTH  PC of faulting instruction, captured into EPC
eret  in  1  return from exception: redirect to EPC
pc  out  WIDTH  current fetch PC (registered)
pc_next_seq  out  WIDTH  pc + STEP, combinational, modulo 2^WIDTH
epc  out  WIDTH  exception PC register
redirect_pending  out  1  a stalled redirect is buffered
misaligned  out  1  combinational; pc mod STEP != 0

Behaviour:
- Reset (rst=1 at edge) overrides everything:
  - pc <= RESET_VECTOR, epc <= 0, pending cleared.
  - Outputs are valid the cycle after.
- Redirect target decode:
  - 01: {pc_4_id[WIDTH-1:WIDTH-4], jump_off}
  - 10: beq_target
  - 11: jr_target
- Per-edge priority when rst=0. The first matching rule applies:
  1. exc=1: pc <= EXC_VECTOR, epc <= exc_pc, pending cleared. Ignores pc_write and pc_src. exc together with eret: exc wins and eret is dropped.
  2. eret=1: pc <= epc (old value), pending cleared. Ignores pc_write.
  3. pc_write=1, pc_src!=00: pc <= decoded target; pending cleared (newer redirect supersedes the buffered one).
  4. pc_write=1, pc_src=00, pending valid: pc <= pending target; pending cleared.
  5. pc_write=1, pc_src=00, no pending: pc <= pc + STEP, wrapping modulo 2^WIDTH.
  6. pc_write=0, pc_src!=00: pc holds; pending target <= decoded target, pending <= 1. Overwrites any older pending.
  7. pc_write=0, pc_src=00: pc and pending hold.
- Latency:
  - Every redirect is visible on pc exactly one edge after it is accepted.
  - A stalled redirect is visible one edge after pc_write returns to 1.
- epc changes only on exc or rst.
- Alignment: no masking; a misaligned target is loaded as given and misaligned is flagged.
- No X propagation: all state registers are reset.

Test Plan:
- Reset then 3 cycles of pc_write=1, pc_src=00 -> pc = 0, 4, 8, 12; epc=0; redirect_pending=0. Hold pc at 32'hFFFF_FFFC, step -> pc = 0 (wrap).
- At pc=8, pc_src=10, beq_target=32'h40 -> next pc = 32'h40. Then pc_src=01, pc_4_id=32'hA000_0010, jump_off=28'h0000100 -> pc = 32'hA000_0100. Then pc_src=11, jr_target=32'h1234 -> pc = 32'h1234.
- pc_write=0 with pc_src=10, beq_target=32'h200 -> pc holds, redirect_pending=1. Two more stall cycles with pc_src=00 -> pc still holds. pc_write=1, pc_src=00 -> pc = 32'h200, pending=0. Repeat the stall, but release with pc_src=11, jr_target=32'h300 -> pc = 32'h300 (new redirect wins).
- pc=32'h50, pc_write=0, exc=1, exc_pc=32'h4C -> pc = 32'h80, epc = 32'h4C, pending cleared. Later eret=1 -> pc = 32'h4C.
- Same edge: exc=1, exc_pc=32'h10, eret=1, pc_src=10 -> pc = EXC_VECTOR, epc = 32'h10.
- Mid-stall with pending valid, rst=1 -> pc = RESET_VECTOR, pending=0, epc=0. Instantiate with WIDTH=16, STEP=2, RESET_VECTOR=16'h0100 -> sequence 0x100, 0x102, 0x104. jr_target=16'h0101 -> misaligned=1.
